// File: rtl/mips_memsys.sv
// Unified instruction/data memory for the multicycle mips core: byte-stream program loader,
// word RAM, and two memory-mapped I/O words (output register, free-running cycle counter).
module mips_memsys #(
    parameter int unsigned ADDR_W      = 10,
    parameter logic [15:0] IO_OUT_ADDR = 16'hFFF0,
    parameter logic [15:0] CYC_ADDR    = 16'hFFF4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] memAddr,
    input  logic        MemWrite,
    input  logic [31:0] writeMemData,
    output logic [31:0] memData,
    output logic        cpu_reset,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        ld_err,
    output logic [31:0] io_out
);

    localparam int unsigned     DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] PTR_MAX = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {StLoad, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       shift_q, shift_d;
    logic              ld_err_q, ld_err_d;
    logic [31:0]       io_out_q, io_out_d;
    logic [31:0]       cyc_q, cyc_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              ld_ready_q, ld_ready_d;

    logic [31:0]       ram_q [DEPTH];

    logic [13:0]       word_addr;
    logic              io_hit, cyc_hit, ram_hit;
    logic [ADDR_W-1:0] ram_idx;

    logic              xfer, word_due, ptr_full;
    logic [31:0]       asm_word;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [31:0]       ram_wdata;

    // Core address decode; I/O words win over RAM when ADDR_W makes them overlap.
    always_comb begin
        word_addr = memAddr[15:2];
        io_hit    = (word_addr == IO_OUT_ADDR[15:2]);
        cyc_hit   = (word_addr == CYC_ADDR[15:2]);
        ram_hit   = !io_hit && !cyc_hit && ({18'd0, word_addr} < DEPTH);
        ram_idx   = memAddr[ADDR_W+1:2];

        memData = 32'd0;
        if (io_hit) begin
            memData = io_out_q;
        end else if (cyc_hit) begin
            memData = cyc_q;
        end else if (ram_hit) begin
            memData = ram_q[ram_idx];
        end
    end

    // Loader word assembly: earlier bytes sit in shift_q, newest byte is ld_byte.
    always_comb begin
        xfer     = ld_valid && ld_ready_q && (state_q == StLoad);
        word_due = xfer && ((idx_q == 2'd3) || ld_last);
        ptr_full = (ptr_q == PTR_MAX);

        asm_word = 32'd0;
        case (idx_q)
            2'd0:    asm_word = {ld_byte, 24'd0};
            2'd1:    asm_word = {shift_q[7:0], ld_byte, 16'd0};
            2'd2:    asm_word = {shift_q[15:0], ld_byte, 8'd0};
            default: asm_word = {shift_q[23:0], ld_byte};
        endcase
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = ptr_q[ADDR_W-1:0];
        ram_wdata = asm_word;
        if (state_q == StLoad) begin
            ram_we = word_due && !ptr_full;
        end else begin
            ram_we    = MemWrite && ram_hit;
            ram_waddr = ram_idx;
            ram_wdata = writeMemData;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        ld_err_d    = ld_err_q;
        io_out_d    = io_out_q;
        cyc_d       = cyc_q;
        cpu_reset_d = cpu_reset_q;
        ld_ready_d  = ld_ready_q;

        unique case (state_q)
            StLoad: begin
                cyc_d       = 32'd0;
                cpu_reset_d = 1'b1;
                ld_ready_d  = 1'b1;
                if (word_due) begin
                    idx_d   = 2'd0;
                    shift_d = 24'd0;
                    // ptr saturates at DEPTH; overflowing words are dropped and flagged.
                    if (ptr_full) begin
                        ld_err_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end else if (xfer) begin
                    idx_d   = idx_q + 2'd1;
                    shift_d = {shift_q[15:0], ld_byte};
                end
                if (xfer && ld_last) begin
                    state_d     = StRun;
                    cpu_reset_d = 1'b0;
                    ld_ready_d  = 1'b0;
                end
            end
            StRun: begin
                cpu_reset_d = 1'b0;
                ld_ready_d  = 1'b0;
                cyc_d       = cyc_q + 32'd1;
                if (MemWrite && io_hit) begin
                    io_out_d = writeMemData;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StLoad;
            ptr_q       <= '0;
            idx_q       <= 2'd0;
            shift_q     <= 24'd0;
            ld_err_q    <= 1'b0;
            io_out_q    <= 32'd0;
            cyc_q       <= 32'd0;
            cpu_reset_q <= 1'b1;
            ld_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            ld_err_q    <= ld_err_d;
            io_out_q    <= io_out_d;
            cyc_q       <= cyc_d;
            cpu_reset_q <= cpu_reset_d;
            ld_ready_q  <= ld_ready_d;
        end
    end

    // RAM contents survive reset so a reloaded image only overwrites what it covers.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_waddr] <= ram_wdata;
        end
    end

    assign cpu_reset = cpu_reset_q;
    assign ld_ready  = ld_ready_q;
    assign ld_err    = ld_err_q;
    assign io_out    = io_out_q;

endmodule

// File: tb/tb_mips_memsys.sv
// Directed bench for mips_memsys: a default-size instance plus an ADDR_W=2 instance
// sharing all inputs, checked against hand-computed values.
module tb_mips_memsys;

    logic        clk;
    logic        reset;
    logic [15:0] mem_addr;
    logic        mem_write;
    logic [31:0] wdata;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;

    logic [31:0] md, md_s;
    logic        cpu_rst, cpu_rst_s;
    logic        ldr, ldr_s;
    logic        lde, lde_s;
    logic [31:0] ioo, ioo_s;

    int n_checks = 0;
    int n_fail   = 0;

    mips_memsys dut (
        .clk          (clk),
        .reset        (reset),
        .memAddr      (mem_addr),
        .MemWrite     (mem_write),
        .writeMemData (wdata),
        .memData      (md),
        .cpu_reset    (cpu_rst),
        .ld_valid     (ld_valid),
        .ld_byte      (ld_byte),
        .ld_last      (ld_last),
        .ld_ready     (ldr),
        .ld_err       (lde),
        .io_out       (ioo)
    );

    mips_memsys #(.ADDR_W(2)) dut_s (
        .clk          (clk),
        .reset        (reset),
        .memAddr      (mem_addr),
        .MemWrite     (mem_write),
        .writeMemData (wdata),
        .memData      (md_s),
        .cpu_reset    (cpu_rst_s),
        .ld_valid     (ld_valid),
        .ld_byte      (ld_byte),
        .ld_last      (ld_last),
        .ld_ready     (ldr_s),
        .ld_err       (lde_s),
        .io_out       (ioo_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic last, input int gap);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        repeat (gap) step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic rd_check(input string tag, input logic [15:0] a, input logic [31:0] exp);
        mem_addr = a;
        #1;
        check_eq(tag, md, exp);
    endtask

    task automatic rd_check_s(input string tag, input logic [15:0] a, input logic [31:0] exp);
        mem_addr = a;
        #1;
        check_eq(tag, md_s, exp);
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        mem_addr  = a;
        wdata     = d;
        mem_write = 1'b1;
        step();
        mem_write = 1'b0;
    endtask

    logic [7:0]  prog1 [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h10};
    logic [7:0]  prog2 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
    int          gaps2 [6] = '{0, 3, 1, 2, 0, 0};
    logic [31:0] v1, v2;

    initial begin
        reset     = 1'b0;
        mem_addr  = 16'h0000;
        mem_write = 1'b0;
        wdata     = 32'd0;
        ld_valid  = 1'b0;
        ld_byte   = 8'd0;
        ld_last   = 1'b0;
        step();
        step();
        check_eq("rst_cpu_reset", {31'd0, cpu_rst}, 32'd1);
        check_eq("rst_ld_ready", {31'd0, ldr}, 32'd1);
        check_eq("rst_ld_err", {31'd0, lde}, 32'd0);
        check_eq("rst_io_out", ioo, 32'd0);
        reset = 1'b1;

        // Test 1: two-word program, then RUN-mode accesses.
        for (int i = 0; i < 7; i++) send(prog1[i], 1'b0, 0);
        check_eq("t1_cpu_reset_pre", {31'd0, cpu_rst}, 32'd1);
        mem_addr = 16'hFFF4;
        send(prog1[7], 1'b1, 0);
        check_eq("t1_cpu_reset_post", {31'd0, cpu_rst}, 32'd0);
        check_eq("t1_ld_ready_post", {31'd0, ldr}, 32'd0);
        rd_check("t1_cyc_first", 16'hFFF4, 32'd0);
        step();
        rd_check("t1_cyc_second", 16'hFFF4, 32'd1);
        rd_check("t1_ram0", 16'h0000, 32'h20080005);
        rd_check("t1_ram1", 16'h0004, 32'hAC090010);
        check_eq("t1_ld_err", {31'd0, lde}, 32'd0);
        wr(16'h0100, 32'hDEADBEEF);
        rd_check("t1_rd_100", 16'h0100, 32'hDEADBEEF);
        rd_check("t1_rd_103", 16'h0103, 32'hDEADBEEF);
        wr(16'h8000, 32'h12345678);
        rd_check("t1_rd_8000", 16'h8000, 32'd0);
        wr(16'hFFF0, 32'h0000005A);
        check_eq("t1_io_out", ioo, 32'h0000005A);
        rd_check("t1_rd_fff0", 16'hFFF0, 32'h0000005A);
        rd_check("t1_rd_ff00", 16'hFF00, 32'd0);
        mem_addr = 16'hFFF4;
        #1;
        v1 = md;
        step();
        v2 = md;
        check_eq("t1_cyc_step", v2 - v1, 32'd1);
        wr(16'hFFF4, 32'd0);
        v1 = md;
        check_eq("t1_cyc_ro", v1 - v2, 32'd1);

        // Test 2: six bytes with idle gaps; core writes during LOAD must be dropped.
        do_reset();
        check_eq("t2_io_out_rst", ioo, 32'd0);
        wr(16'hFFF0, 32'h0000005A);
        check_eq("t2_io_load_wr", ioo, 32'd0);
        wr(16'h0100, 32'h00000000);
        for (int i = 0; i < 6; i++) send(prog2[i], (i == 5) ? 1'b1 : 1'b0, gaps2[i]);
        check_eq("t2_cpu_reset", {31'd0, cpu_rst}, 32'd0);
        rd_check("t2_ram0", 16'h0000, 32'h11223344);
        rd_check("t2_ram1", 16'h0004, 32'hAABB0000);
        rd_check("t2_ram_load_wr", 16'h0100, 32'hDEADBEEF);
        check_eq("t2_ptr", 32'(dut.ptr_q), 32'd2);

        // Test 3: five words into both instances; the 4-word one overflows.
        do_reset();
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 0);
        check_eq("t3_err_at_full", {31'd0, lde_s}, 32'd0);
        for (int i = 16; i < 20; i++) send(8'(i), (i == 19) ? 1'b1 : 1'b0, 0);
        check_eq("t3_err_s", {31'd0, lde_s}, 32'd1);
        check_eq("t3_cpu_reset_s", {31'd0, cpu_rst_s}, 32'd0);
        check_eq("t3_err_big", {31'd0, lde}, 32'd0);
        rd_check_s("t3_s_ram0", 16'h0000, 32'h00010203);
        rd_check_s("t3_s_ram3", 16'h000C, 32'h0C0D0E0F);
        rd_check_s("t3_s_ram_oob", 16'h0010, 32'd0);
        rd_check("t3_big_ram4", 16'h0010, 32'h10111213);
        wr(16'hFFF0, 32'h00000077);
        check_eq("t3_io_out", ioo, 32'h00000077);

        // Test 4: reset from RUN, then again mid-word, then a clean reload.
        reset = 1'b0;
        step();
        check_eq("t4_cpu_reset_run", {31'd0, cpu_rst}, 32'd1);
        reset = 1'b1;
        send(8'hAA, 1'b0, 0);
        send(8'hBB, 1'b0, 0);
        do_reset();
        check_eq("t4_cpu_reset_mid", {31'd0, cpu_rst}, 32'd1);
        send(8'h01, 1'b0, 0);
        send(8'h02, 1'b0, 0);
        send(8'h03, 1'b0, 0);
        mem_addr = 16'hFFF4;
        send(8'h04, 1'b1, 0);
        rd_check("t4_cyc_zero", 16'hFFF4, 32'd0);
        rd_check("t4_ram0", 16'h0000, 32'h01020304);
        rd_check("t4_io_rd", 16'hFFF0, 32'd0);
        check_eq("t4_io_out", ioo, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_memsys.md
# mips_memsys

Unified instruction/data memory subsystem on the memory side of the multicycle `mips` core. It serves the core's `memAddr`/`MemWrite`/`writeMemData` requests and returns `memData`. After reset it runs a byte-stream program loader that fills the RAM while holding the core in reset, then releases the core. It also decodes two memory-mapped I/O words: an output register and a free-running cycle counter.

## Interface
Parameters:
- `ADDR_W`, 10, log2 of RAM depth in 32-bit words (DEPTH = 2^ADDR_W)
- `IO_OUT_ADDR`, 16'hFFF0, byte address of the I/O output register
- `CYC_ADDR`, 16'hFFF4, byte address of the read-only cycle counter

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-low reset
- `memAddr`  in  16  core byte address; bits [1:0] ignored
- `MemWrite`  in  1  core write strobe
- `writeMemData`  in  32  core write data
- `memData`  out  32  read data to the core (combinational from `memAddr`)
- `cpu_reset`  out  1  active-high reset to the core; high while loading
- `ld_valid`  in  1  loader byte valid
- `ld_byte`  in  8  loader byte, big-endian within a word
- `ld_last`  in  1  marks the final byte of the image, qualified by `ld_valid`
- `ld_ready`  out  1  loader may transfer; a byte transfers when `ld_valid & ld_ready`
- `ld_err`  out  1  sticky: image exceeded RAM depth
- `io_out`  out  32  I/O output register

## Operation
- FSM states: LOAD and RUN. `reset`=0 forces LOAD, clears the load pointer, byte index, byte shift register, `ld_err`, `io_out` and the cycle counter. RAM contents are not cleared.
- LOAD:
  - `ld_ready`=1, `cpu_reset`=1.
  - Each transferred byte shifts into a 24-bit assembly register. Byte index 0..3: the first byte goes to [31:24].
  - On the 4th byte, the assembled word is written to RAM[ptr], ptr increments, and the index returns to 0.
  - On a byte with `ld_last`=1: the partial word is zero-padded in its low bytes and written to RAM[ptr], then the FSM goes to RUN. A `ld_last` that lands on the 4th byte writes just that one word.
  - If ptr = DEPTH when a word write is due, the write is dropped and `ld_err` is set. ptr saturates at DEPTH and does not wrap.
  - Core `MemWrite` is ignored in LOAD.
- RUN:
  - `ld_ready`=0, `cpu_reset`=0. Loader inputs are ignored.
  - Stays in RUN until `reset`=0.
- Address decode, applied to every core access:
  - RAM: `memAddr[15:2]` < DEPTH. A read returns RAM[`memAddr[ADDR_W+1:2]`]. A write in RUN writes the full word at the clock edge.
  - `IO_OUT_ADDR`: a read returns `io_out`. A write in RUN loads `io_out`.
  - `CYC_ADDR`: a read returns the counter. Writes are ignored.
  - Any other address reads 0, and writes to it are ignored. The I/O decode takes priority over RAM.
- Cycle counter: 32 bits, increments once per RUN cycle, wraps from FFFFFFFF to 0, holds at 0 in LOAD.

## Timing
- Reset values (registered outputs): `cpu_reset`=1, `ld_ready`=1, `ld_err`=0, `io_out`=0. After reset, `memData` is a pure function of `memAddr` and the current state.
- `memData`: zero-cycle combinational read. A write at edge N is visible on `memData` from just after edge N (write-then-read, no bypass needed within a cycle).
- A byte accepted at edge N with index 3 or with `ld_last` updates RAM at edge N.
- `ld_last` accepted at edge N: state = RUN, `cpu_reset`=0 and `ld_ready`=0 from just after edge N. The counter reads 0 in the first RUN cycle and 1 in the next.
- `ld_valid` may drop between bytes; partial assembly state is held indefinitely.
- `reset`=0 mid-load or mid-run takes effect at the next edge. A partially assembled word is discarded. `cpu_reset` is 1 from the next edge.

## Test plan
- Load bytes 20,08,00,05,AC,09,00,10 (last on 10) -> RAM[0]=20080005, RAM[1]=AC090010; `cpu_reset` falls right after the edge that accepted the last byte.
- Load 6 bytes 11,22,33,44,AA,BB (last on BB) with `ld_valid` idle gaps of 0-3 cycles -> RAM[0]=11223344, RAM[1]=AABB0000, ptr stops at 2.
- In RUN: write DEADBEEF to 16'h0100, then read 16'h0100 and 16'h0103 -> DEADBEEF both; write to 16'h8000 is ignored, and reading 16'h8000 -> 0.
- In RUN: write 0000005A to FFF0 -> `io_out`=0000005A next cycle. Read FFF4 on two consecutive cycles -> values differ by 1.
- `ADDR_W`=2: load 5 words -> RAM[0..3] written, `ld_err`=1, RAM[0] not overwritten, FSM still enters RUN on `ld_last`.
- `reset`=0 after 2 bytes of a word, then reload 4 bytes 01,02,03,04 last -> RAM[0]=01020304 with no stale bytes; `io_out` and the counter read 0.
